// File: rtl/dvi_link_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dvi_link_sequencer
// Brief    : Bring-up/teardown sequencer for a 3-lane DVI/TMDS link (pixel
//            clock domain). Optional lock-loss counter: DVI_SEQ_LOSS_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dvi_link_sequencer #(
    parameter int LOCK_FILTER   = 64,
    parameter int RESET_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 1024,
    parameter int W_CTR         = 16
) (
    input  logic        clk_pix,
    input  logic        rst_pix,
    input  logic        enable,
    input  logic        pll_locked,
    input  logic        frame_start,
    input  logic [29:0] tmds_in,
    output logic [29:0] tmds_out,
    output logic [9:0]  tmds_clk_out,
    output logic        ser_rst_n,
    output logic        link_up,
    output logic [2:0]  state
`ifdef DVI_SEQ_LOSS_COUNT_EN
    ,
    output logic [7:0]  lock_loss_count
`endif
);

    localparam logic [2:0] S_OFF        = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK  = 3'd1;
    localparam logic [2:0] S_SER_RESET  = 3'd2;
    localparam logic [2:0] S_SETTLE     = 3'd3;
    localparam logic [2:0] S_WAIT_FRAME = 3'd4;
    localparam logic [2:0] S_ACTIVE     = 3'd5;

    localparam logic [9:0]       c_ctrl        = 10'b1101010100;
    localparam logic [9:0]       c_clkpat      = 10'b0000011111;
    localparam logic [W_CTR-1:0] c_lock_last   = W_CTR'(LOCK_FILTER - 1);
    localparam logic [W_CTR-1:0] c_reset_last  = W_CTR'(RESET_CYCLES - 1);
    localparam logic [W_CTR-1:0] c_settle_last = W_CTR'(SETTLE_CYCLES - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [W_CTR-1:0] r_ctr;
    logic [W_CTR-1:0] w_ctr_nxt;
    logic             w_lock_loss;

    logic [29:0]      r_tmds;
    logic [29:0]      w_tmds_nxt;
    logic [9:0]       r_clk_sym;
    logic [9:0]       w_clk_sym_nxt;
    logic             r_ser_rst_n;
    logic             w_ser_rst_n_nxt;
    logic             r_link_up;
    logic             w_link_up_nxt;

    // Lock loss only counts once serialisers have been released from WAIT_LOCK.
    assign w_lock_loss = enable && !pll_locked &&
                         ((r_state == S_SER_RESET) || (r_state == S_SETTLE) ||
                          (r_state == S_WAIT_FRAME) || (r_state == S_ACTIVE));

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_state     <= S_OFF;
            r_ctr       <= '0;
            r_tmds      <= {3{c_ctrl}};
            r_clk_sym   <= '0;
            r_ser_rst_n <= 1'b0;
            r_link_up   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ctr       <= w_ctr_nxt;
            r_tmds      <= w_tmds_nxt;
            r_clk_sym   <= w_clk_sym_nxt;
            r_ser_rst_n <= w_ser_rst_n_nxt;
            r_link_up   <= w_link_up_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ctr_nxt   = r_ctr;
        if (!enable) begin
            w_state_nxt = S_OFF;
            w_ctr_nxt   = '0;
        end else if (w_lock_loss) begin
            w_state_nxt = S_WAIT_LOCK;
            w_ctr_nxt   = '0;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_ctr_nxt   = '0;
                end
                S_WAIT_LOCK: begin
                    if (!pll_locked) begin
                        w_ctr_nxt = '0;
                    end else if (r_ctr == c_lock_last) begin
                        w_state_nxt = S_SER_RESET;
                        w_ctr_nxt   = '0;
                    end else begin
                        w_ctr_nxt = r_ctr + 1'b1;
                    end
                end
                S_SER_RESET: begin
                    if (r_ctr == c_reset_last) begin
                        w_state_nxt = S_SETTLE;
                        w_ctr_nxt   = '0;
                    end else begin
                        w_ctr_nxt = r_ctr + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (r_ctr == c_settle_last) begin
                        w_state_nxt = S_WAIT_FRAME;
                        w_ctr_nxt   = '0;
                    end else begin
                        w_ctr_nxt = r_ctr + 1'b1;
                    end
                end
                S_WAIT_FRAME: begin
                    if (frame_start) begin
                        w_state_nxt = S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    w_state_nxt = S_ACTIVE;
                end
                default: begin
                    w_state_nxt = S_OFF;
                    w_ctr_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are computed from the next state so they change with the state register.
    always_comb begin
        w_ser_rst_n_nxt = !((w_state_nxt == S_OFF) || (w_state_nxt == S_WAIT_LOCK) ||
                            (w_state_nxt == S_SER_RESET));
        w_clk_sym_nxt   = ((w_state_nxt == S_SETTLE) || (w_state_nxt == S_WAIT_FRAME) ||
                           (w_state_nxt == S_ACTIVE)) ? c_clkpat : 10'd0;
        w_link_up_nxt   = (w_state_nxt == S_ACTIVE);
        w_tmds_nxt      = (w_state_nxt == S_ACTIVE) ? tmds_in : {3{c_ctrl}};
    end

`ifdef DVI_SEQ_LOSS_COUNT_EN
    logic [7:0] r_loss_cnt;

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_loss_cnt <= '0;
        end else if (w_lock_loss && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign lock_loss_count = r_loss_cnt;
`endif

    assign state        = r_state;
    assign tmds_out     = r_tmds;
    assign tmds_clk_out = r_clk_sym;
    assign ser_rst_n    = r_ser_rst_n;
    assign link_up      = r_link_up;

endmodule
`default_nettype wire

// File: tb/tb_dvi_link_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dvi_link_sequencer
// Brief    : Randomised and directed bench for dvi_link_sequencer against a
//            behavioural phase/cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dvi_link_sequencer;

    localparam int          LF       = 3;
    localparam int          RC       = 4;
    localparam int          SC       = 8;
    localparam logic [9:0]  CTRL     = 10'b1101010100;
    localparam logic [9:0]  CLKPAT   = 10'b0000011111;
    localparam logic [29:0] CTRL3    = {CTRL, CTRL, CTRL};

    logic        clk;
    logic        rst;
    logic        en;
    logic        lock;
    logic        fs;
    logic [29:0] tin;
    logic [29:0] tmds_out;
    logic [9:0]  tmds_clk_out;
    logic        ser_rst_n;
    logic        link_up;
    logic [2:0]  state;
`ifdef DVI_SEQ_LOSS_COUNT_EN
    logic [7:0]  lock_loss_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: phase number, cycles spent in phase / locked run.
    int          m_phase;
    int          m_cnt;
    int          m_loss;
    logic [29:0] m_tmds;

    dvi_link_sequencer #(
        .LOCK_FILTER  (LF),
        .RESET_CYCLES (RC),
        .SETTLE_CYCLES(SC),
        .W_CTR        (16)
    ) dut (
        .clk_pix     (clk),
        .rst_pix     (rst),
        .enable      (en),
        .pll_locked  (lock),
        .frame_start (fs),
        .tmds_in     (tin),
        .tmds_out    (tmds_out),
        .tmds_clk_out(tmds_clk_out),
        .ser_rst_n   (ser_rst_n),
        .link_up     (link_up),
        .state       (state)
`ifdef DVI_SEQ_LOSS_COUNT_EN
        ,
        .lock_loss_count(lock_loss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [29:0] act, input logic [29:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  np;
        bit  loss;
        if (rst) begin
            m_phase = 0;
            m_cnt   = 0;
            m_loss  = 0;
            m_tmds  = CTRL3;
            return;
        end
        np   = m_phase;
        loss = en && !lock && (m_phase >= 2) && (m_phase <= 5);
        if (!en) begin
            np    = 0;
            m_cnt = 0;
        end else if (loss) begin
            np    = 1;
            m_cnt = 0;
            if (m_loss < 255) m_loss++;
        end else begin
            case (m_phase)
                0: begin np = 1; m_cnt = 0; end
                1: begin
                    if (lock) begin
                        m_cnt++;
                        if (m_cnt >= LF) begin np = 2; m_cnt = 0; end
                    end else begin
                        m_cnt = 0;
                    end
                end
                2: begin m_cnt++; if (m_cnt >= RC) begin np = 3; m_cnt = 0; end end
                3: begin m_cnt++; if (m_cnt >= SC) begin np = 4; m_cnt = 0; end end
                4: if (fs) np = 5;
                default: np = 5;
            endcase
        end
        m_phase = np;
        m_tmds  = (np == 5) ? tin : CTRL3;
    endtask

    task automatic compare();
        chk("state", {27'd0, state}, 30'(m_phase));
        chk("tmds_out", tmds_out, m_tmds);
        chk("tmds_clk_out", {20'd0, tmds_clk_out},
            (m_phase >= 3) ? {20'd0, CLKPAT} : 30'd0);
        chk("ser_rst_n", {29'd0, ser_rst_n}, (m_phase >= 3) ? 30'd1 : 30'd0);
        chk("link_up", {29'd0, link_up}, (m_phase == 5) ? 30'd1 : 30'd0);
`ifdef DVI_SEQ_LOSS_COUNT_EN
        chk("lock_loss_count", {22'd0, lock_loss_count}, 30'(m_loss));
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic go_active();
        int k;
        en   = 1'b1;
        lock = 1'b1;
        fs   = 1'b0;
        k    = 0;
        while (m_phase != 4 && k < 200) begin
            cycle();
            k++;
        end
        chk("go_active_reached_wait_frame", {27'd0, state}, 30'd4);
        fs = 1'b1;
        cycle();
        fs = 1'b0;
        chk("go_active_link_up", {29'd0, link_up}, 30'd1);
    endtask

    initial begin
        int pat[6];
        pat = '{1, 1, 0, 1, 1, 1};
        rst = 1'b1; en = 1'b0; lock = 1'b0; fs = 1'b0; tin = '0;
        m_phase = 0; m_cnt = 0; m_loss = 0; m_tmds = CTRL3;
        repeat (3) cycle();
        chk("reset_state", {27'd0, state}, 30'd0);
        chk("reset_tmds_out", tmds_out, CTRL3);
        chk("reset_clk", {20'd0, tmds_clk_out}, 30'd0);
        chk("reset_ser_rst_n", {29'd0, ser_rst_n}, 30'd0);
        chk("reset_link_up", {29'd0, link_up}, 30'd0);

        // Bring-up; frame_start pulses during SETTLE must not shorten it.
        rst = 1'b0; en = 1'b1; lock = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tin = 30'($urandom);
            cycle();
            if (i == 7)  chk("bringup_ser_rst_n_c7", {29'd0, ser_rst_n}, 30'd0);
            if (i == 8)  chk("bringup_ser_rst_n_c8", {29'd0, ser_rst_n}, 30'd1);
            if (i == 8)  chk("bringup_clk_c8", {20'd0, tmds_clk_out}, {20'd0, CLKPAT});
            if (i == 15) chk("bringup_state_c15", {27'd0, state}, 30'd3);
            if (i == 16) chk("bringup_state_c16", {27'd0, state}, 30'd4);
            fs = (i >= 8 && i <= 14);
        end

        cycle();
        chk("wait_frame_ctrl", tmds_out, CTRL3);
        tin = 30'h2AB_CDEF;
        fs  = 1'b1;
        cycle();
        fs  = 1'b0;
        chk("frame_first_word", tmds_out, 30'h2AB_CDEF);
        chk("frame_link_up", {29'd0, link_up}, 30'd1);

        tin = 30'($urandom); cycle();
        tin = 30'($urandom); cycle();
        lock = 1'b0;
        cycle();
        lock = 1'b1;
        chk("loss_state", {27'd0, state}, 30'd1);
        chk("loss_ser_rst_n", {29'd0, ser_rst_n}, 30'd0);
        chk("loss_link_up", {29'd0, link_up}, 30'd0);
        chk("loss_tmds_out", tmds_out, CTRL3);
`ifdef DVI_SEQ_LOSS_COUNT_EN
        chk("loss_count_1", {22'd0, lock_loss_count}, 30'd1);
`endif

        go_active();
        en = 1'b0; lock = 1'b0;
        cycle();
        chk("simul_state_off", {27'd0, state}, 30'd0);
`ifdef DVI_SEQ_LOSS_COUNT_EN
        chk("simul_count_unchanged", {22'd0, lock_loss_count}, 30'd1);
`endif

        // Lock filter: a dropout restarts the consecutive-lock count.
        do_reset();
        en = 1'b1; lock = 1'b0;
        cycle();
        for (int j = 0; j < 6; j++) begin
            lock = pat[j][0];
            cycle();
            chk("lockfilter_state", {27'd0, state}, (j == 5) ? 30'd2 : 30'd1);
        end
`ifdef DVI_SEQ_LOSS_COUNT_EN
        chk("lockfilter_count_0", {22'd0, lock_loss_count}, 30'd0);
`endif

        for (int i = 0; i < 4000; i++) begin
            rst  = ($urandom_range(0, 699) == 0);
            en   = ($urandom_range(0, 199) != 0);
            lock = ($urandom_range(0, 59) != 0);
            fs   = ($urandom_range(0, 9) == 0);
            tin  = 30'($urandom);
            cycle();
        end
        rst = 1'b0;

`ifdef DVI_SEQ_LOSS_COUNT_EN
        do_reset();
        en = 1'b1; lock = 1'b1; fs = 1'b0;
        cycle();
        for (int e = 0; e < 300; e++) begin
            lock = 1'b1;
            repeat (3) cycle();
            lock = 1'b0;
            cycle();
        end
        lock = 1'b1;
        chk("sat_count_255", {22'd0, lock_loss_count}, 30'd255);
        do_reset();
        chk("sat_reset_0", {22'd0, lock_loss_count}, 30'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
